// File: rtl/overlay_fetch_sched_if.sv
// SDRAM channel bus between the overlay fetch scheduler (master) and the sdram controller (slave).
interface overlay_fetch_sched_if;
    logic        mem_req;
    logic        mem_rnw;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_ack;
    logic [31:0] mem_dout;

    modport master (
        output mem_req, mem_rnw, mem_addr, mem_din,
        input  mem_ack, mem_dout
    );

    modport slave (
        input  mem_req, mem_rnw, mem_addr, mem_din,
        output mem_ack, mem_dout
    );
endinterface

// File: rtl/overlay_fetch_sched.sv
// Overlay SDRAM scheduler: download writes vs raster prefetch reads into a pixel FIFO.
// Define OVERLAY_FETCH_STATS_EN to add per-frame underrun count and minimum FIFO level outputs.
module overlay_fetch_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int SKIP_W     = 4
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         dl_active,
    input  logic                         dl_wr,
    input  logic [24:0]                  dl_addr,
    input  logic [7:0]                   dl_data,
    input  logic                         vs,
    input  logic                         de,
    input  logic                         ce_pix,
    output logic [15:0]                  pix_rgba,
    output logic                         pix_valid,
    output logic                         underflow,
`ifdef OVERLAY_FETCH_STATS_EN
    output logic [15:0]                  stat_underruns,
    output logic [$clog2(FIFO_DEPTH):0]  stat_fifo_min,
`endif
    overlay_fetch_sched_if.master        mem
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SKIP_W-1:0] SKIP_MAX = {SKIP_W{1'b1}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;
    localparam logic [1:0] FLUSH   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d, rnw_q, rnw_d;
    logic [23:0]       addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic [7:0]        lo_q, lo_d;
    logic              hold_vld_q, hold_vld_d;
    logic [23:0]       hold_addr_q, hold_addr_d;
    logic [15:0]       hold_data_q, hold_data_d;
    logic [23:0]       rd_addr_q, rd_addr_d;
    logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              half_q, half_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [15:0]       pix_q, pix_d;
    logic              pvld_q, pvld_d, unf_q, unf_d;
    logic              vs_q;
    logic [31:0]       fifo_q [FIFO_DEPTH];

    logic        vs_rise, active, flush, pair, strobe, fifo_empty;
    logic        rd_ack, push, discard, pop, empty_odd, issue_wr;
    logic [31:0] head;

    assign vs_rise    = vs & ~vs_q;
    assign active     = enable & ~dl_active;
    // Any of these invalidates the prefetched stream and restarts it at address 0.
    assign flush      = vs_rise | ~active;
    assign pair       = dl_active & dl_wr & dl_addr[0];
    assign strobe     = ce_pix & de & ~flush;
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rptr_q];
    assign rd_ack     = (state_q == RD_WAIT) & mem.mem_ack & ~flush;
    assign push       = rd_ack & (skip_q == '0);
    assign discard    = rd_ack & (skip_q != '0);
    assign pop        = strobe & ~fifo_empty & half_q;
    assign empty_odd  = strobe & fifo_empty & half_q;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        din_d       = din_q;
        lo_d        = lo_q;
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        rd_addr_d   = rd_addr_q;
        issue_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    issue_wr = 1'b1;
                    req_d    = 1'b1;
                    rnw_d    = 1'b0;
                    addr_d   = hold_addr_q;
                    din_d    = hold_data_q;
                    state_d  = WR_WAIT;
                end else if (!flush && cnt_q < DEPTH_C) begin
                    req_d   = 1'b1;
                    rnw_d   = 1'b1;
                    addr_d  = rd_addr_q;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem.mem_ack) begin
                    req_d     = 1'b0;
                    state_d   = IDLE;
                    rd_addr_d = rd_addr_q + 24'd2;
                end else if (flush) begin
                    state_d = FLUSH;
                end
            end
            WR_WAIT, FLUSH: begin
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dl_active && dl_wr && !dl_addr[0])
            lo_d = dl_data;

        // Hold frees as it is copied onto the bus, so a pair can queue behind an in-flight write.
        if (issue_wr)
            hold_vld_d = 1'b0;
        if (pair && (!hold_vld_q || issue_wr)) begin
            hold_vld_d  = 1'b1;
            hold_addr_d = dl_addr[24:1];
            hold_data_d = {dl_data, lo_q};
        end

        if (flush)
            rd_addr_d = '0;
    end

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        skip_d = skip_q;
        pix_d  = pix_q;
        pvld_d = 1'b0;
        unf_d  = unf_q;

        if (push)
            wptr_d = wptr_q + 1'b1;
        if (pop)
            rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (strobe) begin
            half_d = ~half_q;
            if (fifo_empty) begin
                pix_d = '0;
                unf_d = 1'b1;
            end else begin
                pix_d  = half_q ? head[31:16] : head[15:0];
                pvld_d = 1'b1;
            end
        end

        // Skip counts words whose pixels were already missed; they are dropped on arrival.
        if (discard && !empty_odd)
            skip_d = skip_q - 1'b1;
        else if (empty_odd && !discard && skip_q != SKIP_MAX)
            skip_d = skip_q + 1'b1;

        if (!active)
            pix_d = '0;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
            half_d = 1'b0;
            skip_d = '0;
        end
        if (vs_rise)
            unf_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            lo_q        <= '0;
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            rd_addr_q   <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            skip_q      <= '0;
            pix_q       <= '0;
            pvld_q      <= 1'b0;
            unf_q       <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            lo_q        <= lo_d;
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            rd_addr_q   <= rd_addr_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            skip_q      <= skip_d;
            pix_q       <= pix_d;
            pvld_q      <= pvld_d;
            unf_q       <= unf_d;
            vs_q        <= vs;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_q[wptr_q] <= mem.mem_dout;
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_rnw  = rnw_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = din_q;
    assign pix_rgba     = pix_q;
    assign pix_valid    = pvld_q;
    assign underflow    = unf_q;

`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0]   urun_q, stat_urun_q;
    logic [CW-1:0] lvl_min_q, stat_min_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            urun_q      <= '0;
            stat_urun_q <= '0;
            lvl_min_q   <= DEPTH_C;
            stat_min_q  <= '0;
        end else if (vs_rise) begin
            stat_urun_q <= urun_q;
            stat_min_q  <= lvl_min_q;
            urun_q      <= '0;
            lvl_min_q   <= DEPTH_C;
        end else begin
            if (strobe && fifo_empty && urun_q != 16'hFFFF)
                urun_q <= urun_q + 1'b1;
            if (de && cnt_q < lvl_min_q)
                lvl_min_q <= cnt_q;
        end
    end

    assign stat_underruns = stat_urun_q;
    assign stat_fifo_min  = stat_min_q;
`endif

endmodule

// File: tb/tb_overlay_fetch_sched.sv
// Scoreboard bench for overlay_fetch_sched: SDRAM responder model plus queued pixel expectations.
module tb_overlay_fetch_sched;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        enable, dl_active, dl_wr, vs, de, ce_pix;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic [15:0] pix_rgba;
    logic        pix_valid, underflow;
`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0] stat_underruns;
    logic [3:0]  stat_fifo_min;
`endif

    overlay_fetch_sched_if bus ();

    overlay_fetch_sched #(.FIFO_DEPTH(8), .SKIP_W(4)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .enable    (enable),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .vs        (vs),
        .de        (de),
        .ce_pix    (ce_pix),
        .pix_rgba  (pix_rgba),
        .pix_valid (pix_valid),
        .underflow (underflow),
`ifdef OVERLAY_FETCH_STATS_EN
        .stat_underruns (stat_underruns),
        .stat_fifo_min  (stat_fifo_min),
`endif
        .mem       (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_bad = 0;

    logic [40:0] req_log [$];
    logic [31:0] rd_words [$];
    logic [16:0] exp_pix [$];
    int          ack_lat  = 3;
    bit          ack_hold = 1'b0;
    bit          in_req   = 1'b0;
    int          wait_cnt = 0;
    logic [40:0] cur_req;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'hF1, a[7:0], 8'hE0, a[7:0]};
    endfunction

    // SDRAM responder: logs each new request, acks after ack_lat cycles unless held.
    always @(negedge clk_sys) begin
        if (bus.mem_ack)
            check_val("req_drop", {63'd0, bus.mem_req}, 64'd0);
        bus.mem_ack = 1'b0;
        if (!reset_n) begin
            in_req = 1'b0;
        end else if (bus.mem_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                wait_cnt = 0;
                cur_req  = {bus.mem_rnw, bus.mem_addr, bus.mem_din};
                req_log.push_back(cur_req);
            end
            if (!ack_hold)
                wait_cnt++;
            if (wait_cnt >= ack_lat) begin
                check_val("req_stable", {23'd0, bus.mem_rnw, bus.mem_addr, bus.mem_din}, {23'd0, cur_req});
                bus.mem_ack = 1'b1;
                if (!bus.mem_rnw)
                    bus.mem_dout = 32'h0;
                else if (rd_words.size() > 0)
                    bus.mem_dout = rd_words.pop_front();
                else
                    bus.mem_dout = mem_word(bus.mem_addr);
                in_req = 1'b0;
            end
        end
    end

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
    endtask

    task automatic vs_pulse();
        @(negedge clk_sys);
        vs = 1'b1;
        @(negedge clk_sys);
        vs = 1'b0;
    endtask

    task automatic pix_strobe(input string tag, input logic v, input logic [15:0] px);
        logic [16:0] e;
        exp_pix.push_back({v, px});
        @(negedge clk_sys);
        ce_pix = 1'b1;
        @(negedge clk_sys);
        ce_pix = 1'b0;
        e = exp_pix.pop_front();
        check_val(tag, {47'd0, pix_valid, pix_rgba}, {47'd0, e});
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.mem_req && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check_val(tag, {63'd0, bus.mem_req}, 64'd1);
    endtask

    task automatic log_entry(input string tag, input int idx, input logic [40:0] exp, input bit full);
        if (idx >= req_log.size())
            check_val(tag, 64'd0, 64'd1);
        else if (full)
            check_val(tag, {23'd0, req_log[idx]}, {23'd0, exp});
        else
            check_val(tag, {39'd0, req_log[idx][40:16]}, {39'd0, exp[40:16]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        vs = 1'b0; de = 1'b0; ce_pix = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_val("rst_pix",   {48'd0, pix_rgba}, 64'd0);
        check_val("rst_pvld",  {63'd0, pix_valid}, 64'd0);
        check_val("rst_unf",   {63'd0, underflow}, 64'd0);
        check_val("rst_req",   {63'd0, bus.mem_req}, 64'd0);
        check_val("rst_rnw",   {63'd0, bus.mem_rnw}, 64'd0);
        check_val("rst_addr",  {40'd0, bus.mem_addr}, 64'd0);
        check_val("rst_din",   {48'd0, bus.mem_din}, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Download: two byte pairs back to back
        ack_lat = 2;
        dl_active = 1'b1;
        dl_byte(25'd0, 8'h34);
        dl_byte(25'd1, 8'h12);
        dl_byte(25'd2, 8'h78);
        dl_byte(25'd3, 8'h56);
        @(negedge clk_sys);
        dl_wr = 1'b0;
        repeat (20) @(negedge clk_sys);
        check_val("dl_count", req_log.size(), 64'd2);
        log_entry("dl_wr0", 0, {1'b0, 24'd0, 16'h1234}, 1'b1);
        log_entry("dl_wr1", 1, {1'b0, 24'd1, 16'h5678}, 1'b1);
        dl_active = 1'b0;

        // Prefetch after enable + vs
        req_log.delete();
        ack_lat = 3;
        rd_words.push_back(32'hBBBBAAAA);
        rd_words.push_back(32'hDDDDCCCC);
        @(negedge clk_sys);
        enable = 1'b1;
        vs = 1'b1;
        @(negedge clk_sys);
        vs = 1'b0;
        repeat (100) @(negedge clk_sys);
        check_val("pf_count", req_log.size(), 64'd8);
        for (int i = 0; i < 8; i++)
            log_entry("pf_addr", i, {1'b1, 24'(2 * i), 16'h0}, 1'b0);
        check_val("pf_idle", {63'd0, bus.mem_req}, 64'd0);

        // Streaming
        de = 1'b1;
        pix_strobe("st_px0", 1'b1, 16'hAAAA);
        pix_strobe("st_px1", 1'b1, 16'hBBBB);
        pix_strobe("st_px2", 1'b1, 16'hCCCC);
        pix_strobe("st_px3", 1'b1, 16'hDDDD);
        de = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_val("hold_px",   {48'd0, pix_rgba}, {48'd0, 16'hDDDD});
        check_val("hold_pvld", {63'd0, pix_valid}, 64'd0);
        repeat (40) @(negedge clk_sys);

        // Underflow with ack held off, then skip recovery
        ack_hold = 1'b1;
        req_log.delete();
        vs_pulse();
        de = 1'b1;
        pix_strobe("uf_px0", 1'b0, 16'h0000);
        pix_strobe("uf_px1", 1'b0, 16'h0000);
        pix_strobe("uf_px2", 1'b0, 16'h0000);
        pix_strobe("uf_px3", 1'b0, 16'h0000);
        check_val("uf_flag", {63'd0, underflow}, 64'd1);
        rd_words.push_back(32'h0A0A0B0B);
        rd_words.push_back(32'h0C0C0D0D);
        rd_words.push_back(32'h56781234);
        ack_hold = 1'b0;
        repeat (50) @(negedge clk_sys);
        pix_strobe("uf_rec0", 1'b1, 16'h1234);
        pix_strobe("uf_rec1", 1'b1, 16'h5678);
        check_val("uf_sticky", {63'd0, underflow}, 64'd1);
        log_entry("uf_rd0", 0, {1'b1, 24'd0, 16'h0}, 1'b0);
        log_entry("uf_rd1", 1, {1'b1, 24'd2, 16'h0}, 1'b0);
        log_entry("uf_rd2", 2, {1'b1, 24'd4, 16'h0}, 1'b0);
        de = 1'b0;
        repeat (40) @(negedge clk_sys);

        // vs while a read is outstanding
        ack_hold = 1'b1;
        req_log.delete();
        vs_pulse();
        check_val("fl_unf_clr0", {63'd0, underflow}, 64'd0);
        wait_req("fl_req");
        de = 1'b1;
        pix_strobe("fl_empty", 1'b0, 16'h0000);
        de = 1'b0;
        check_val("fl_unf_set", {63'd0, underflow}, 64'd1);
        rd_words.push_back(32'hEEEEEEEE);
        rd_words.push_back(32'h99998888);
        vs_pulse();
        check_val("fl_unf_clr", {63'd0, underflow}, 64'd0);
        ack_hold = 1'b0;
        repeat (40) @(negedge clk_sys);
        log_entry("fl_rd0", 0, {1'b1, 24'd0, 16'h0}, 1'b0);
        log_entry("fl_rd1", 1, {1'b1, 24'd0, 16'h0}, 1'b0);
        de = 1'b1;
        pix_strobe("fl_px", 1'b1, 16'h8888);
        de = 1'b0;
        repeat (40) @(negedge clk_sys);

        // Download pair arriving during an outstanding read
        ack_hold = 1'b1;
        req_log.delete();
        vs_pulse();
        wait_req("rw_req");
        dl_active = 1'b1;
        dl_byte(25'h20, 8'hCD);
        dl_byte(25'h21, 8'hAB);
        @(negedge clk_sys);
        dl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        ack_hold = 1'b0;
        repeat (30) @(negedge clk_sys);
        check_val("rw_count", req_log.size(), 64'd2);
        log_entry("rw_rd", 0, {1'b1, 24'd0, 16'h0}, 1'b0);
        log_entry("rw_wr", 1, {1'b0, 24'h10, 16'hABCD}, 1'b1);
        check_val("rw_pix_off", {47'd0, pix_valid, pix_rgba}, 64'd0);
        dl_active = 1'b0;
        repeat (5) @(negedge clk_sys);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
